dvp_camera_emulator: RTL and testbench
======================================

# dvp_camera_emulator

Synthesizable OV7670-style DVP transmitter that produces `cam_vsync`/`href`/`p_data` framing with RGB565 pixels, two bytes per pixel, from an internal coordinate pattern. It is the transmit counterpart of the camera capture path: it drives the same pins the camera handler samples, so the full capture → FIFO → PSRAM → LCD chain can be exercised on hardware and in simulation without a sensor. Outputs are registered in a single clock domain, and the receiver samples them on the same clock.

## Interface

Parameters:

- `FRAME_WIDTH`, default 640, pixels per line (≥1, ≤1024).
- `FRAME_HEIGHT`, default 480, lines per frame (≥1, ≤1024).
- `VSYNC_CYCLES`, default 3, cycles `cam_vsync` is high (≥1).
- `V_BACK_CYCLES`, default 17, cycles from `cam_vsync` fall to the first `href` (≥1).
- `H_BLANK_CYCLES`, default 144, cycles `href` is low between lines (≥1).
- `V_FRONT_CYCLES`, default 10, cycles after the last line before the frame ends (≥1).

Ports (one clock; reset is asynchronous and active-high):

- `clk`  in  1  pixel-byte clock; all outputs update on its rising edge.
- `reset_p`  in  1  asynchronous, active-high reset.
- `enable`  in  1  start/continue frame generation; sampled only in IDLE.
- `cam_vsync`  out  1  frame sync, high during VSYNC.
- `href`  out  1  line valid, high for 2·FRAME_WIDTH cycles per line.
- `p_data`  out  8  pixel byte; 0x00 whenever `href`=0.
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame.
- `frame_cnt`  out  16  count of completed frames; wraps 0xFFFF→0x0000.
- `busy`  out  1  high in every state except IDLE.

## Operation

- FSM states: IDLE → VSYNC → V_BACK → LINE ⇄ H_BLANK → V_FRONT → IDLE.
- IDLE: all outputs low. If `enable`=1 at a clock edge, go to VSYNC.
- VSYNC: `cam_vsync`=1 for VSYNC_CYCLES cycles, then go to V_BACK.
- V_BACK: idle for V_BACK_CYCLES cycles, then go to LINE with y=0.
- LINE: `href`=1 for 2·FRAME_WIDTH cycles.
  - Byte 2x carries pixel[15:8]; byte 2x+1 carries pixel[7:0] (high byte first).
  - Pattern pixel = {y[5:0], x[9:0]}, where x and y are zero-based.
  - At the end of a line: if y<FRAME_HEIGHT−1, go to H_BLANK; otherwise pulse `frame_done`, increment `frame_cnt`, and go to V_FRONT.
- H_BLANK: `href`=0 for H_BLANK_CYCLES cycles, then y←y+1 and go to LINE.
- V_FRONT: wait V_FRONT_CYCLES cycles, then go to IDLE.
- `enable` affects nothing outside IDLE. Dropping `enable` mid-frame completes the current frame.
- Back-to-back frames: `enable` held high costs exactly one IDLE cycle between V_FRONT and the next VSYNC.
- Counters:
  - Cycle counter: 16 bits, reloaded at each state entry.
  - x: 10 bits. y: 10 bits.
  - The byte phase is the LSB of the LINE cycle count.
- Reset (`reset_p`=1, at any time including mid-line): state goes to IDLE immediately and asynchronously; `cam_vsync`, `href`, `p_data`, `frame_done`, `busy` go to 0 and `frame_cnt` goes to 0.

## Timing

- Latency: `enable` sampled high at edge N → `cam_vsync`=1 and `busy`=1 from edge N onward (registered outputs).
- Frame length, from VSYNC entry to IDLE re-entry: VSYNC_CYCLES + V_BACK_CYCLES + FRAME_HEIGHT·2·FRAME_WIDTH + (FRAME_HEIGHT−1)·H_BLANK_CYCLES + V_FRONT_CYCLES cycles.
- `frame_done` is high exactly in the first V_FRONT cycle. `frame_cnt` shows the new value in that same cycle.
- `href` and `p_data` change only on rising edges. `p_data` is stable for one cycle per byte.

## Configuration

- `DVP_EMU_FRAME_TAG_EN` defined: the first pixel of each frame (x=0, y=0) is replaced by `frame_cnt` (the value before increment), sent high byte first. All other pixels are unchanged. This lets the receiver check frame ordering and detect drops.
- Not defined: every pixel follows the pattern, so the first pixel is always 0x0000.

## Test plan

All scenarios use FRAME_WIDTH=4, FRAME_HEIGHT=2, VSYNC_CYCLES=3, V_BACK_CYCLES=2, H_BLANK_CYCLES=2, V_FRONT_CYCLES=2.

- Single frame: pulse `enable` for 1 cycle → `cam_vsync` high for 3 cycles; `href` high for 8 cycles, low for 2, high for 8; `frame_done` pulses once; `frame_cnt`=1; total `busy`=25 cycles.
- Byte content: line 0 `p_data` = 00 00 00 01 00 02 00 03; line 1 = 04 00 04 01 04 02 04 03; `p_data`=0x00 whenever `href`=0.
- Continuous: `enable` held high for 3 frames → frames are 26 cycles apart (25 + 1 IDLE); `frame_cnt` steps 1, 2, 3.
- Enable drop: deassert `enable` during line 0 → the frame completes normally, then the block stays in IDLE with `busy`=0.
- Reset mid-line: assert `reset_p` during byte 3 of line 1 → `href`=0, `p_data`=0, `frame_cnt`=0 without waiting for a clock edge; the next `enable` starts a fresh frame at y=0.
- Tag mode (`DVP_EMU_FRAME_TAG_EN`): in the second frame, the first two bytes are 00 01 instead of 00 00; all other bytes match the pattern.

Source files
------------

// File: rtl/dvp_camera_emulator.sv
// ============================================================================
// Module  : dvp_camera_emulator
// Purpose : OV7670-style DVP transmitter (vsync/href/RGB565 bytes) driven by
//           an internal {y,x} coordinate pattern.
// Options : DVP_EMU_FRAME_TAG_EN - first pixel of each frame carries frame_cnt
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dvp_camera_emulator #(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int VSYNC_CYCLES   = 3,
  parameter int V_BACK_CYCLES  = 17,
  parameter int H_BLANK_CYCLES = 144,
  parameter int V_FRONT_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        enable,
  output logic        cam_vsync,
  output logic        href,
  output logic [7:0]  p_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_VSYNC   = 3'd1;
  localparam logic [2:0] c_V_BACK  = 3'd2;
  localparam logic [2:0] c_LINE    = 3'd3;
  localparam logic [2:0] c_H_BLANK = 3'd4;
  localparam logic [2:0] c_V_FRONT = 3'd5;

  localparam logic [15:0] c_VSYNC_LAST   = 16'(VSYNC_CYCLES - 1);
  localparam logic [15:0] c_V_BACK_LAST  = 16'(V_BACK_CYCLES - 1);
  localparam logic [15:0] c_LINE_LAST    = 16'(2 * FRAME_WIDTH - 1);
  localparam logic [15:0] c_H_BLANK_LAST = 16'(H_BLANK_CYCLES - 1);
  localparam logic [15:0] c_V_FRONT_LAST = 16'(V_FRONT_CYCLES - 1);
  localparam logic [9:0]  c_Y_LAST       = 10'(FRAME_HEIGHT - 1);

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [9:0]  r_y;
  logic        r_vsync;
  logic        r_href;
  logic [7:0]  r_pdata;
  logic        r_frame_done;
  logic [15:0] r_frame_cnt;
  logic        r_busy;

  logic [2:0]  w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [9:0]  w_y_nxt;
  logic [9:0]  w_x_nxt;
  logic [15:0] w_pixel;
  logic [7:0]  w_byte;
  logic        w_frame_end;

  // Next-state view; outputs are registered from it so they line up with state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 16'd1;
    w_y_nxt     = r_y;
    case (r_state)
      c_IDLE: begin
        w_cnt_nxt = '0;
        if (enable) w_state_nxt = c_VSYNC;
      end
      c_VSYNC: begin
        if (r_cnt == c_VSYNC_LAST) begin
          w_state_nxt = c_V_BACK;
          w_cnt_nxt   = '0;
        end
      end
      c_V_BACK: begin
        if (r_cnt == c_V_BACK_LAST) begin
          w_state_nxt = c_LINE;
          w_cnt_nxt   = '0;
          w_y_nxt     = '0;
        end
      end
      c_LINE: begin
        if (r_cnt == c_LINE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_y < c_Y_LAST) ? c_H_BLANK : c_V_FRONT;
        end
      end
      c_H_BLANK: begin
        if (r_cnt == c_H_BLANK_LAST) begin
          w_state_nxt = c_LINE;
          w_cnt_nxt   = '0;
          w_y_nxt     = r_y + 10'd1;
        end
      end
      c_V_FRONT: begin
        if (r_cnt == c_V_FRONT_LAST) begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Byte phase is the LSB of the line count; the rest is the pixel column.
  always_comb begin
    w_x_nxt = w_cnt_nxt[10:1];
    w_pixel = {w_y_nxt[5:0], w_x_nxt};
`ifdef DVP_EMU_FRAME_TAG_EN
    if ((w_x_nxt == 10'd0) && (w_y_nxt == 10'd0)) w_pixel = r_frame_cnt;
`endif
    w_byte      = w_cnt_nxt[0] ? w_pixel[7:0] : w_pixel[15:8];
    w_frame_end = (r_state == c_LINE) && (w_state_nxt == c_V_FRONT);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state      <= c_IDLE;
      r_cnt        <= '0;
      r_y          <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_pdata      <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_y          <= w_y_nxt;
      r_vsync      <= (w_state_nxt == c_VSYNC);
      r_href       <= (w_state_nxt == c_LINE);
      r_pdata      <= (w_state_nxt == c_LINE) ? w_byte : 8'h00;
      r_frame_done <= w_frame_end;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
      r_busy       <= (w_state_nxt != c_IDLE);
    end
  end

  assign cam_vsync  = r_vsync;
  assign href       = r_href;
  assign p_data     = r_pdata;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_dvp_camera_emulator.sv
// ============================================================================
// Module  : tb_dvp_camera_emulator
// Purpose : Scoreboard bench for dvp_camera_emulator on a 4x2 frame.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dvp_camera_emulator;

  localparam int FW = 4;
  localparam int FH = 2;
  localparam int VS = 3;
  localparam int VB = 2;
  localparam int HB = 2;
  localparam int VF = 2;
  localparam int FRAME_LEN = 25;
  localparam int FRAME_PERIOD = 26;
`ifdef DVP_EMU_FRAME_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam logic [7:0] PATTERN [16] = '{
    8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03,
    8'h04, 8'h00, 8'h04, 8'h01, 8'h04, 8'h02, 8'h04, 8'h03};

  logic        clk;
  logic        reset_p;
  logic        enable;
  logic        cam_vsync;
  logic        href;
  logic [7:0]  p_data;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [7:0]  exp_bytes [$];
  logic [15:0] exp_fcnt  [$];
  int          vs_rise   [$];

  dvp_camera_emulator #(
    .FRAME_WIDTH   (FW),
    .FRAME_HEIGHT  (FH),
    .VSYNC_CYCLES  (VS),
    .V_BACK_CYCLES (VB),
    .H_BLANK_CYCLES(HB),
    .V_FRONT_CYCLES(VF)
  ) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .enable    (enable),
    .cam_vsync (cam_vsync),
    .href      (href),
    .p_data    (p_data),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [15:0] tag, input int nbytes,
                            input bit push_cnt, input logic [15:0] cnt_after);
    logic [15:0] first_px;
    logic [7:0]  b;
    first_px = TAG_EN ? tag : 16'h0000;
    for (int i = 0; i < nbytes; i++) begin
      b = PATTERN[i];
      if (i == 0) b = first_px[15:8];
      if (i == 1) b = first_px[7:0];
      exp_bytes.push_back(b);
    end
    if (push_cnt) exp_fcnt.push_back(cnt_after);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < bound);
    check({name, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    check("vsync_latency", {31'd0, cam_vsync}, 32'd1);
    check("busy_latency", {31'd0, busy}, 32'd1);
    enable = 1'b0;
  endtask

  // Monitor: pops expected bytes / frame counts and measures sync run lengths.
  initial begin : monitor
    logic p_href, p_vs, p_busy;
    int   href_run, vs_run, busy_run, gap;
    bit   gap_valid;
    logic [7:0]  e;
    logic [15:0] ec;
    p_href = 0; p_vs = 0; p_busy = 0;
    href_run = 0; vs_run = 0; busy_run = 0; gap = 0; gap_valid = 0;
    forever begin
      @(negedge clk);
      if (reset_p) begin
        p_href = 0; p_vs = 0; p_busy = 0;
        href_run = 0; vs_run = 0; busy_run = 0; gap_valid = 0;
        continue;
      end
      if (href) begin
        if (exp_bytes.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_byte: got 0x%0h, expected none", p_data);
        end else begin
          e = exp_bytes.pop_front();
          check("p_data", {24'd0, p_data}, {24'd0, e});
        end
        if (!p_href && gap_valid) check("h_blank_len", gap, HB);
        href_run++;
      end else begin
        check("p_data_idle", {24'd0, p_data}, 32'd0);
        if (p_href) begin
          check("href_len", href_run, 2 * FW);
          href_run  = 0;
          gap_valid = 1;
          gap       = 0;
        end
        gap++;
      end
      if (cam_vsync) begin
        if (!p_vs) vs_rise.push_back(cyc);
        vs_run++;
        gap_valid = 0;
      end else if (p_vs) begin
        check("vsync_len", vs_run, VS);
        vs_run = 0;
      end
      if (busy) busy_run++;
      else if (p_busy) begin
        check("busy_len", busy_run, FRAME_LEN);
        busy_run = 0;
      end
      if (frame_done) begin
        check("done_after_line", {31'd0, p_href}, 32'd1);
        if (exp_fcnt.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_frame_done: frame_cnt 0x%0h, expected none", frame_cnt);
        end else begin
          ec = exp_fcnt.pop_front();
          check("frame_cnt_at_done", {16'd0, frame_cnt}, {16'd0, ec});
        end
      end
      p_href = href; p_vs = cam_vsync; p_busy = busy;
    end
  end

  initial begin : stimulus
    int  n;
    int  rises;
    bit  prev;
    bit  stayed_idle;
    reset_p = 1'b1;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vsync", {31'd0, cam_vsync}, 32'd0);
    check("rst_href", {31'd0, href}, 32'd0);
    check("rst_p_data", {24'd0, p_data}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    #1 reset_p = 1'b0;

    // Single frame from a one-cycle enable pulse
    push_frame(16'd0, 16, 1'b1, 16'd1);
    start_pulse();
    wait_idle("single", 100);
    check("single_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("single_queue_empty", exp_bytes.size(), 0);

    // Three back-to-back frames with enable held high
    vs_rise.delete();
    push_frame(16'd1, 16, 1'b1, 16'd2);
    push_frame(16'd2, 16, 1'b1, 16'd3);
    push_frame(16'd3, 16, 1'b1, 16'd4);
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (vs_rise.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cont_three_vsyncs", vs_rise.size(), 3);
    enable = 1'b0;
    wait_idle("cont", 100);
    if (vs_rise.size() >= 3) begin
      check("cont_period_1", vs_rise[1] - vs_rise[0], FRAME_PERIOD);
      check("cont_period_2", vs_rise[2] - vs_rise[1], FRAME_PERIOD);
    end
    check("cont_frame_cnt", {16'd0, frame_cnt}, 32'd4);

    // Enable dropped during line 0
    push_frame(16'd4, 16, 1'b1, 16'd5);
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!href && n < 50);
    check("drop_href_seen", {31'd0, href}, 32'd1);
    enable = 1'b0;
    wait_idle("drop", 100);
    stayed_idle = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (busy || cam_vsync) stayed_idle = 1'b0;
    end
    check("drop_stays_idle", {31'd0, stayed_idle}, 32'd1);
    check("drop_frame_cnt", {16'd0, frame_cnt}, 32'd5);

    // Asynchronous reset during byte 3 of line 1
    push_frame(16'd5, 12, 1'b0, 16'd0);
    start_pulse();
    rises = 0;
    prev  = 1'b0;
    n     = 0;
    while (rises < 2 && n < 100) begin
      @(posedge clk);
      #1;
      if (href && !prev) rises++;
      prev = href;
      n++;
    end
    check("reset_line1_seen", rises, 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset_p = 1'b1;
    #1;
    check("async_href", {31'd0, href}, 32'd0);
    check("async_p_data", {24'd0, p_data}, 32'd0);
    check("async_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_queue_empty", exp_bytes.size(), 0);
    repeat (2) @(negedge clk);
    #1 reset_p = 1'b0;

    // Fresh frame after reset starts at y=0 with frame_cnt 0
    push_frame(16'd0, 16, 1'b1, 16'd1);
    start_pulse();
    wait_idle("fresh", 100);
    check("fresh_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("final_byte_queue", exp_bytes.size(), 0);
    check("final_cnt_queue", exp_fcnt.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
